enemy_spawn_scheduler: RTL and testbench
========================================

Name: enemy_spawn_scheduler

Overview:
Sequences a pool of Enemy sprite instances for the race game. It decides when each enemy slot enters the screen and which lane (x offset) it uses. It parks slots that have left the bottom of the screen, counts dodged enemies as score, and freezes all enemies on a player collision. It sits between the game top level and the Enemy instances, and drives their offset_x, enable, reset and collision inputs.

Parameters:
NUM_ENEMIES, 3, number of Enemy slots managed (1..8)
LANE_COUNT, 4, number of road lanes (1..8)
LANE_X0, 160, x offset of lane 0 in pixels
LANE_PITCH, 100, x distance between adjacent lanes in pixels
SPAWN_GAP, 120, minimum number of ticks between two spawns (>=1)
SCREEN_END, 600, pos_y value at which an enemy counts as passed
CRASH_HOLD, 180, number of ticks the freeze is held after a collision (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick  in  1  one-clk pulse per game logic update (logic_clk rate)
start  in  1  level; begins a game from IDLE
collision  in  1  player/enemy collision flag, sampled on clk
enemy_pos_y  in  10*NUM_ENEMIES  packed pos_y of each slot; slot i is at [10i+9:10i]
enemy_offset_x  out  10*NUM_ENEMIES  packed lane x offset per slot
enemy_enable  out  NUM_ENEMIES  per-slot enable, high while the slot is active
enemy_park  out  NUM_ENEMIES  per-slot reset to Enemy (active-high), high while the slot is idle
freeze  out  1  drives the Enemy collision inputs; high in CRASH
score  out  16  number of enemies passed, saturating
state  out  2  0=IDLE, 1=RUN, 2=CRASH

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, freeze=0, score=0.
  - enemy_enable=0, enemy_park=all 1s, enemy_offset_x=all LANE_X0.
  - active mask=0, gap counter=0, hold counter=0, last_lane=0, LFSR=8'hA5.
- All state updates occur on the clk rising edge. Outputs are registered, so a decision taken on a tick cycle is visible on the next clk edge.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1. It advances on every tick in every state and never reaches 0.
- IDLE:
  - All slots are parked.
  - start=1 -> RUN. On that edge: score=0, gap counter=0, active mask=0.
- RUN, per tick, with gap counter nonzero: the gap counter decrements.
- RUN, per tick, with gap counter==0 and at least one idle slot (spawn):
  - Spawn into the lowest-index idle slot.
  - lane = LFSR mod LANE_COUNT. If lane==last_lane and LANE_COUNT>1, use (lane+1) mod LANE_COUNT instead.
  - offset_x[slot] = LANE_X0 + lane*LANE_PITCH (10-bit, truncated). enable[slot]=1, park[slot]=0.
  - Set the slot's active bit. last_lane=lane. Gap counter = SPAWN_GAP-1.
- RUN, per tick, with gap counter==0 and no idle slot: the gap counter holds at 0 and the spawn occurs on the first tick a slot becomes idle.
- RUN, retire (evaluated every clk, not only on tick):
  - Any active slot with pos_y==SCREEN_END clears its active bit, enable=0, park=1.
  - score += number of slots retiring that cycle, saturating at 16'hFFFF.
  - A slot retired this cycle is not eligible for a spawn in the same cycle.
- RUN, collision=1 -> CRASH:
  - freeze=1, hold counter=CRASH_HOLD-1.
  - Collision has priority: no spawn and no retire/score on that edge.
- CRASH:
  - freeze stays 1. enable, park, offset_x and the active mask hold. The hold counter decrements per tick.
  - On a tick with hold counter==0 -> IDLE: freeze=0, all slots parked, active mask=0. score is retained.
- start while in RUN or CRASH is ignored. collision in IDLE or CRASH is ignored.
- A reset asserted mid-game forces the reset values immediately, regardless of state.

Test Plan:
- Reset, start=1 for 1 clk, ticks every 4 clk -> first spawn on slot 0 at the first tick; offset_x0 = 160+100*(lane); next spawn on slot 1 exactly 120 ticks later.
- Force enemy_pos_y slot0=600 while active -> next clk: enable[0]=0, park[0]=1, score=1; slot0 reused by the next spawn.
- Slots 0 and 2 reach 600 in the same clk -> score increments by 2 in one edge.
- collision=1 coinciding with a spawn tick and slot1 pos_y=600 -> state=CRASH, freeze=1, no spawn, score unchanged; 180 ticks later state=IDLE, freeze=0, park=all 1s.
- Preload score=16'hFFFE, retire 3 slots -> score=16'hFFFF.
- Run 1000 spawns -> no two consecutive spawns in the same lane; all offset_x values lie in {160,260,360,460}. Assert reset mid-RUN -> all outputs return to reset values with no clk edge.

Source files
------------

// File: rtl/enemy_spawn_scheduler_if.sv
// Signal bundle between the game top level and the enemy spawn scheduler.
// Signal directions are named from the scheduler's side (_i into it, _o out of it).
interface enemy_spawn_scheduler_if #(
  parameter int NUM_ENEMIES = 3
);
  logic                      tick_i;
  logic                      start_i;
  logic                      collision_i;
  logic [10*NUM_ENEMIES-1:0] enemy_pos_y_i;
  logic [10*NUM_ENEMIES-1:0] enemy_offset_x_o;
  logic [NUM_ENEMIES-1:0]    enemy_enable_o;
  logic [NUM_ENEMIES-1:0]    enemy_park_o;
  logic                      freeze_o;
  logic [15:0]               score_o;
  logic [1:0]                state_o;

  modport master (
    output tick_i, start_i, collision_i, enemy_pos_y_i,
    input  enemy_offset_x_o, enemy_enable_o, enemy_park_o, freeze_o, score_o, state_o
  );

  modport slave (
    input  tick_i, start_i, collision_i, enemy_pos_y_i,
    output enemy_offset_x_o, enemy_enable_o, enemy_park_o, freeze_o, score_o, state_o
  );
endinterface

// File: rtl/enemy_spawn_scheduler.sv
// Enemy pool sequencer: spawns enemies into random lanes, retires those that
// leave the screen (scoring them), and freezes the pool after a player crash.
module enemy_spawn_scheduler #(
  parameter int NUM_ENEMIES = 3,
  parameter int LANE_COUNT  = 4,
  parameter int LANE_X0     = 160,
  parameter int LANE_PITCH  = 100,
  parameter int SPAWN_GAP   = 120,
  parameter int SCREEN_END  = 600,
  parameter int CRASH_HOLD  = 180
) (
  input logic                    clk,
  input logic                    reset,
  enemy_spawn_scheduler_if.slave bus
);

  localparam int GAP_W  = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam int HOLD_W = (CRASH_HOLD > 1) ? $clog2(CRASH_HOLD) : 1;
  localparam int IDX_W  = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;

  localparam logic [GAP_W-1:0]  GAP_RELOAD  = GAP_W'(SPAWN_GAP - 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(CRASH_HOLD - 1);
  localparam logic [9:0]        X0          = 10'(LANE_X0);
  localparam logic [9:0]        Y_END       = 10'(SCREEN_END);
  localparam logic [2:0]        LANE_LAST   = 3'(LANE_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CRASH = 2'd2
  } state_e;

  state_e                    state_q;
  logic                      freeze_q;
  logic [15:0]               score_q;
  logic [NUM_ENEMIES-1:0]    active_q;
  logic [NUM_ENEMIES-1:0]    park_q;
  logic [10*NUM_ENEMIES-1:0] offset_q;
  logic [GAP_W-1:0]          gap_q;
  logic [HOLD_W-1:0]         hold_q;
  logic [2:0]                last_lane_q;
  logic [7:0]                lfsr_q;

  logic [7:0]             lfsr_d;
  logic [15:0]            score_d;
  logic [16:0]            score_sum;
  logic [NUM_ENEMIES-1:0] retire;
  logic [3:0]             retire_cnt;
  logic                   idle_found;
  logic [IDX_W-1:0]       idle_idx;
  logic                   spawn;
  logic [NUM_ENEMIES-1:0] spawn_mask;
  logic [2:0]             lane_raw;
  logic [2:0]             lane_pick;
  logic [9:0]             lane_x;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    lfsr_d = lfsr_q;
    if (bus.tick_i) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    retire     = '0;
    retire_cnt = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      if (active_q[i] && (bus.enemy_pos_y_i[10*i +: 10] == Y_END)) begin
        retire[i]  = 1'b1;
        retire_cnt = retire_cnt + 4'd1;
      end
    end
    score_sum = {1'b0, score_q} + {13'd0, retire_cnt};
    score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];

    // Idle is judged before this cycle's retires, so a slot leaving now is not reused now.
    idle_found = 1'b0;
    idle_idx   = '0;
    for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        idle_found = 1'b1;
        idle_idx   = IDX_W'(i);
      end
    end

    lane_raw  = 3'(lfsr_q % 8'(LANE_COUNT));
    lane_pick = lane_raw;
    if ((LANE_COUNT > 1) && (lane_raw == last_lane_q)) begin
      lane_pick = (lane_raw == LANE_LAST) ? 3'd0 : lane_raw + 3'd1;
    end
    lane_x = X0 + 10'(32'(lane_pick) * LANE_PITCH);

    spawn      = bus.tick_i && (gap_q == '0) && idle_found;
    spawn_mask = '0;
    if (spawn) begin
      spawn_mask[idle_idx] = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      freeze_q    <= 1'b0;
      score_q     <= '0;
      active_q    <= '0;
      park_q      <= '1;
      offset_q    <= {NUM_ENEMIES{X0}};
      gap_q       <= '0;
      hold_q      <= '0;
      last_lane_q <= '0;
      lfsr_q      <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
      unique case (state_q)
        ST_IDLE: begin
          active_q <= '0;
          park_q   <= '1;
          if (bus.start_i) begin
            state_q <= ST_RUN;
            score_q <= '0;
            gap_q   <= '0;
          end
        end
        ST_RUN: begin
          if (bus.collision_i) begin
            state_q  <= ST_CRASH;
            freeze_q <= 1'b1;
            hold_q   <= HOLD_RELOAD;
          end else begin
            active_q <= (active_q & ~retire) | spawn_mask;
            park_q   <= (park_q | retire) & ~spawn_mask;
            score_q  <= score_d;
            if (bus.tick_i) begin
              if (gap_q != '0) begin
                gap_q <= gap_q - GAP_W'(1);
              end else if (idle_found) begin
                offset_q[10*idle_idx +: 10] <= lane_x;
                last_lane_q                 <= lane_pick;
                gap_q                       <= GAP_RELOAD;
              end
            end
          end
        end
        ST_CRASH: begin
          if (bus.tick_i) begin
            if (hold_q == '0) begin
              state_q  <= ST_IDLE;
              freeze_q <= 1'b0;
              active_q <= '0;
              park_q   <= '1;
            end else begin
              hold_q <= hold_q - HOLD_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.enemy_offset_x_o = offset_q;
  assign bus.enemy_enable_o   = active_q;
  assign bus.enemy_park_o     = park_q;
  assign bus.freeze_o         = freeze_q;
  assign bus.score_o          = score_q;
  assign bus.state_o          = state_q;

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Bench for enemy_spawn_scheduler: a game-level model checks the default
// instance every cycle; a fast second instance exercises lanes and score saturation.
module tb_enemy_spawn_scheduler;

  localparam int N = 3;
  localparam logic [29:0] OFF_RST = {3{10'd160}};

  logic clk;
  logic reset;
  logic reset2;
  int   n_checks = 0;
  int   n_errors = 0;

  enemy_spawn_scheduler_if #(.NUM_ENEMIES(N)) bus ();
  enemy_spawn_scheduler_if #(.NUM_ENEMIES(2)) bus2 ();

  enemy_spawn_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  enemy_spawn_scheduler #(.NUM_ENEMIES(2), .SPAWN_GAP(1)) dut2 (
    .clk   (clk),
    .reset (reset2),
    .bus   (bus2.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- game-level model of the default instance ----------------
  int m_state, m_score, m_gap, m_hold, m_last, m_lfsr, m_first, m_nret, m_lane;
  int m_act [N];
  int m_off [N];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state = 0; m_score = 0; m_gap = 0; m_hold = 0; m_last = 0; m_lfsr = 8'hA5;
      for (int i = 0; i < N; i++) begin
        m_act[i] = 0;
        m_off[i] = 160;
      end
    end else begin
      case (m_state)
        0: if (bus.start_i) begin
          m_state = 1; m_score = 0; m_gap = 0;
          for (int i = 0; i < N; i++) m_act[i] = 0;
        end
        1: if (bus.collision_i) begin
          m_state = 2;
          m_hold  = 179;
        end else begin
          m_first = -1;
          for (int i = 0; i < N; i++) if (m_act[i] == 0 && m_first < 0) m_first = i;
          m_nret = 0;
          for (int i = 0; i < N; i++) begin
            if (m_act[i] != 0 && bus.enemy_pos_y_i[10*i +: 10] == 10'd600) begin
              m_act[i] = 0;
              m_nret++;
            end
          end
          m_score = (m_score + m_nret > 65535) ? 65535 : m_score + m_nret;
          if (bus.tick_i) begin
            if (m_gap > 0) m_gap--;
            else if (m_first >= 0) begin
              m_lane = m_lfsr % 4;
              if (m_lane == m_last) m_lane = (m_lane + 1) % 4;
              m_act[m_first] = 1;
              m_off[m_first] = (160 + 100 * m_lane) % 1024;
              m_last = m_lane;
              m_gap  = 119;
            end
          end
        end
        default: if (bus.tick_i) begin
          if (m_hold == 0) begin
            m_state = 0;
            for (int i = 0; i < N; i++) m_act[i] = 0;
          end else m_hold--;
        end
      endcase
      if (bus.tick_i)
        m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1)) & 255;
    end
  end

  function automatic logic [31:0] model_enable();
    logic [31:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = (m_act[i] != 0);
    return v;
  endfunction

  function automatic logic [31:0] model_offsets();
    logic [31:0] v = '0;
    for (int i = 0; i < N; i++) v[10*i +: 10] = 10'(m_off[i]);
    return v;
  endfunction

  always @(negedge clk) begin
    check("model_state",  32'(bus.state_o),          32'(m_state));
    check("model_freeze", 32'(bus.freeze_o),         32'(m_state == 2));
    check("model_score",  32'(bus.score_o),          32'(m_score));
    check("model_enable", 32'(bus.enemy_enable_o),   model_enable());
    check("model_park",   32'(bus.enemy_park_o),     ~model_enable() & 32'h7);
    check("model_offset", 32'(bus.enemy_offset_x_o), model_offsets());
  end

  // ---------------- directed sequence on the default instance ----------------
  task automatic run_ticks(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); bus.tick_i = 1'b1;
      @(negedge clk); bus.tick_i = 1'b0;
      repeat (period - 2) @(negedge clk);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},  32'(bus.state_o),          32'd0);
    check({tag, "_freeze"}, 32'(bus.freeze_o),         32'd0);
    check({tag, "_score"},  32'(bus.score_o),          32'd0);
    check({tag, "_enable"}, 32'(bus.enemy_enable_o),   32'd0);
    check({tag, "_park"},   32'(bus.enemy_park_o),     32'h7);
    check({tag, "_offset"}, 32'(bus.enemy_offset_x_o), 32'(OFF_RST));
  endtask

  task automatic main_seq();
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b1;

    @(negedge clk); bus.collision_i = 1'b1;
    @(negedge clk); bus.collision_i = 1'b0;
    check("idle_collision_ignored", 32'(bus.state_o), 32'd0);

    bus.start_i = 1'b1;
    @(negedge clk); bus.start_i = 1'b0;
    check("start_to_run", 32'(bus.state_o), 32'd1);

    // LFSR still at A5 -> lane 1 -> x = 260
    run_ticks(1, 4);
    check("first_spawn_enable",  32'(bus.enemy_enable_o), 32'b001);
    check("first_spawn_offset0", 32'(bus.enemy_offset_x_o[9:0]), 32'd260);
    check("first_spawn_park",    32'(bus.enemy_park_o), 32'b110);
    run_ticks(119, 4);
    check("gap_119_no_spawn", 32'(bus.enemy_enable_o), 32'b001);
    run_ticks(1, 4);
    check("gap_120_spawn_slot1", 32'(bus.enemy_enable_o), 32'b011);

    @(negedge clk); bus.enemy_pos_y_i[9:0] = 10'd600;
    @(negedge clk); bus.enemy_pos_y_i[9:0] = 10'd0;
    check("retire0_enable", 32'(bus.enemy_enable_o), 32'b010);
    check("retire0_park",   32'(bus.enemy_park_o),   32'b101);
    check("retire0_score",  32'(bus.score_o),        32'd1);

    run_ticks(120, 2);
    check("slot0_reused", 32'(bus.enemy_enable_o), 32'b011);
    run_ticks(120, 2);
    check("slot2_spawn", 32'(bus.enemy_enable_o), 32'b111);

    @(negedge clk); bus.enemy_pos_y_i = {10'd600, 10'd0, 10'd600};
    @(negedge clk); bus.enemy_pos_y_i = '0;
    check("dual_retire_score",  32'(bus.score_o),        32'd3);
    check("dual_retire_enable", 32'(bus.enemy_enable_o), 32'b010);

    // Next tick would spawn; collision and a retire coincide with it.
    run_ticks(119, 2);
    bus.tick_i = 1'b1; bus.collision_i = 1'b1; bus.enemy_pos_y_i[19:10] = 10'd600;
    @(negedge clk); bus.tick_i = 1'b0; bus.collision_i = 1'b0;
    check("crash_state",  32'(bus.state_o),        32'd2);
    check("crash_freeze", 32'(bus.freeze_o),       32'd1);
    check("crash_enable", 32'(bus.enemy_enable_o), 32'b010);
    check("crash_score",  32'(bus.score_o),        32'd3);
    run_ticks(179, 2);
    check("crash_hold_179", 32'(bus.state_o), 32'd2);
    run_ticks(1, 2);
    check("crash_exit_state",  32'(bus.state_o),      32'd0);
    check("crash_exit_freeze", 32'(bus.freeze_o),     32'd0);
    check("crash_exit_park",   32'(bus.enemy_park_o), 32'h7);
    check("crash_exit_score",  32'(bus.score_o),      32'd3);

    // start held high into RUN must not clear the score again
    bus.enemy_pos_y_i = '0;
    bus.start_i = 1'b1;
    run_ticks(1, 2);
    check("restart_score",  32'(bus.score_o),        32'd0);
    check("restart_enable", 32'(bus.enemy_enable_o), 32'b001);
    @(negedge clk); bus.enemy_pos_y_i[9:0] = 10'd600;
    @(negedge clk); bus.enemy_pos_y_i[9:0] = 10'd0; bus.start_i = 1'b0;
    check("start_ignored_in_run", 32'(bus.score_o), 32'd1);

    @(posedge clk); #2 reset = 1'b0;
    #1 check_reset_values("async_rst");
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- lane rule and score saturation on the fast instance ----------------
  task automatic sat_seq();
    logic [9:0] off;
    logic [9:0] prev_off = '0;
    int slot;
    int exp_score;
    repeat (2) @(negedge clk);
    reset2 = 1'b1;
    @(negedge clk); bus2.start_i = 1'b1;
    @(negedge clk); bus2.start_i = 1'b0;
    // Both slots sit at the screen end: one spawn and one retire every clk.
    for (int k = 1; k <= 65540; k++) begin
      @(negedge clk);
      exp_score = (k - 1 > 65535) ? 65535 : k - 1;
      slot = (k % 2 == 1) ? 0 : 1;
      off  = bus2.enemy_offset_x_o[10*slot +: 10];
      check("sat_score",  32'(bus2.score_o),        32'(exp_score));
      check("sat_enable", 32'(bus2.enemy_enable_o), (slot == 0) ? 32'b01 : 32'b10);
      if (k <= 1000) begin
        check("lane_in_set", 32'(off == 10'd160 || off == 10'd260 || off == 10'd360 || off == 10'd460), 32'd1);
        if (k > 1) check("lane_differs", 32'(off != prev_off), 32'd1);
      end
      prev_off = off;
    end
    check("sat_final", 32'(bus2.score_o), 32'hFFFF);
  endtask

  initial begin
    reset = 1'b0;
    reset2 = 1'b0;
    bus.tick_i = 1'b0; bus.start_i = 1'b0; bus.collision_i = 1'b0; bus.enemy_pos_y_i = '0;
    bus2.tick_i = 1'b1; bus2.start_i = 1'b0; bus2.collision_i = 1'b0;
    bus2.enemy_pos_y_i = {10'd600, 10'd600};
    fork
      main_seq();
      sat_seq();
    join
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
